// File: rtl/ff_arb_pkg.sv
// Shared types and helpers for the flip-flop bank round-robin arbiter.
package ff_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, ACK, GAP} arb_state_t;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 16;

  // Widest ack vector; callers truncate to their own NUM_REQ.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set req bit after ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               valid,
  output logic [IW-1:0]      idx
);

  int          k;
  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    cand  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      cand = IW'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ff_share_arbiter.sv
// Round-robin arbiter sharing one clock-enabled flip-flop bank between NUM_REQ producers.
// Optional per-requester saturating grant counters: define FF_ARB_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request; winner picked and data snapshotted on exit
// GRANT | CE pulsed to the bank with the snapshotted D
// ACK   | ack pulsed to the winner; rotation pointer advances
// GAP   | enforced quiet time of IDLE_GAP cycles, requests ignored
module ff_share_arbiter
  import ff_arb_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  DATA_W   = 8,
  parameter int  IDLE_GAP = 0,
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                      CK,
  input  logic                      SR,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      CE,
  output logic [DATA_W-1:0]         D,
  output logic [NUM_REQ-1:0]        ack,
  output logic [IW-1:0]             grant_idx,
  output logic                      busy
`ifdef FF_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

  localparam logic [7:0] GAP_INIT = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        gap_q, gap_d;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gidx_d  = pick_idx;
          data_d  = req_data[pick_idx*DATA_W +: DATA_W];
          state_d = GRANT;
        end
      end
      GRANT: state_d = ACK;
      ACK: begin
        ptr_d = gidx_q;
        if (IDLE_GAP > 0) begin
          gap_d   = GAP_INIT;
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to the top index so requester 0 wins the first round.
  always_ff @(posedge CK) begin
    if (SR) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
    end
  end

  assign CE        = (state_q == GRANT);
  assign D         = data_q;
  assign ack       = (state_q == ACK) ? NUM_REQ'(onehot(4'(gidx_q))) : '0;
  assign grant_idx = gidx_q;
  assign busy      = (state_q != IDLE);

`ifdef FF_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NUM_REQ];
  logic [STAT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ACK && cnt_q[gidx_q] != '1)
      cnt_d[gidx_q] = cnt_q[gidx_q] + 1'b1;
  end

  always_ff @(posedge CK) begin
    if (SR) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
  end
`endif

endmodule
